// File: rtl/mock_cu_multi.sv
// mock_cu_multi
//   Mock control unit on Parallel Channel "B" (bus-and-tag). It answers
//   NUM_DEVICES consecutive device addresses starting at BASE_ADDRESS.
//   Supported commands are TEST I/O (00), WRITE (01), READ (02), NOP (03)
//   and SENSE (04). A shared byte buffer lets data written by the channel
//   be read back. When this unit is not selected, select-out is passed on
//   to Channel "A".
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   b_*_out (inputs)     channel outbound bus and tags
//   b_*_in  (outputs)    inbound bus and tags; every tag is registered
//   a_select_out/in      select chain to Channel "A"
//   mock_busy            forces a busy response
//   mock_limit           bytes per READ/WRITE; 0 means no data phase
//   command, device      last command byte, offset of last selected device
//   count                bytes moved in the current or last data phase
//   selected             high from address match until ending status
module mock_cu_multi #(
  parameter logic [7:0] BASE_ADDRESS      = 8'h10,
  parameter int         NUM_DEVICES       = 4,
  parameter int         BUFFER_DEPTH      = 64,
  parameter bit         ENABLE_SHORT_BUSY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] b_bus_in,
  input  logic [7:0] b_bus_out,
  input  logic       b_operational_out,
  output logic       b_request_in,
  input  logic       b_hold_out,
  input  logic       b_select_out,
  output logic       b_select_in,
  input  logic       b_address_out,
  output logic       b_operational_in,
  output logic       b_address_in,
  input  logic       b_command_out,
  output logic       b_status_in,
  output logic       b_service_in,
  input  logic       b_service_out,
  input  logic       b_suppress_out,
  output logic       a_select_out,
  input  logic       a_select_in,
  input  logic       mock_busy,
  input  logic [7:0] mock_limit,
  output logic [7:0] command,
  output logic [3:0] device,
  output logic [8:0] count,
  output logic       selected
);

  localparam int AW = $clog2(BUFFER_DEPTH);

  localparam logic [7:0] CMD_TIO = 8'h00;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] CMD_NOP = 8'h03;
  localparam logic [7:0] CMD_SNS = 8'h04;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BUSY    = 8'h08;
  localparam logic [7:0] ST_END     = 8'h30;
  localparam logic [7:0] ST_OVERRUN = 8'h32;
  localparam logic [7:0] ST_REJECT  = 8'h70;
  localparam logic [7:0] ST_SBUSY   = 8'h48;

  // Range check is done in 9 bits so BASE+NUM-1 == 8'hFF cannot wrap.
  localparam logic [8:0] ADDR_LO = {1'b0, BASE_ADDRESS};
  localparam logic [8:0] ADDR_HI = ADDR_LO + 9'(NUM_DEVICES) - 9'd1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SBUSY,
    S_SBUSY_WAIT,
    S_ADDR_WAIT,
    S_ADDR_IN,
    S_CMD_WAIT,
    S_INIT_STATUS,
    S_INIT_WAIT,
    S_DATA,
    S_DATA_WAIT,
    S_STOP_WAIT,
    S_END_STATUS
  } state_t;

  state_t      state_q;
  logic [7:0]  bus_in_q;
  logic        op_in_q, addr_in_q, status_in_q, service_in_q;
  logic        sel_in_q, a_sel_q;
  logic [7:0]  cmd_q;
  logic [3:0]  dev_q;
  logic [8:0]  count_q;
  logic        selected_q;
  logic [7:0]  sense_q;
  logic [7:0]  status_q;

  logic [7:0]  mem_q [BUFFER_DEPTH];

  // Address decode
  logic        addr_hit_d;
  logic [7:0]  dev_off_d;
  assign addr_hit_d = b_address_out & b_select_out &
                      ({1'b0, b_bus_out} >= ADDR_LO) &
                      ({1'b0, b_bus_out} <= ADDR_HI);
  assign dev_off_d  = b_bus_out - BASE_ADDRESS;

  // SENSE always moves one byte whatever the mock limit says.
  logic [8:0]  xfer_lim_d;
  assign xfer_lim_d = (cmd_q == CMD_SNS) ? 9'd1 : {1'b0, mock_limit};

  // Initial status chosen once command-out has dropped.
  logic [7:0]  init_st_d;
  logic        reject_d;
  always_comb begin
    init_st_d = ST_OK;
    reject_d  = 1'b0;
    if (mock_busy) begin
      init_st_d = ST_BUSY;
    end else begin
      case (cmd_q)
        CMD_TIO, CMD_WR, CMD_RD, CMD_SNS: init_st_d = ST_OK;
        CMD_NOP: init_st_d = ST_END;
        default: begin
          init_st_d = ST_REJECT;
          reject_d  = 1'b1;
        end
      endcase
    end
  end

  // Byte presented for the next inbound transfer. On data-phase entry
  // count has not been cleared yet, so address 0 is forced there.
  logic [AW-1:0] rd_addr_d;
  logic [7:0]    rd_byte_d;
  always_comb begin
    rd_addr_d = (state_q == S_INIT_WAIT) ? '0 : count_q[AW-1:0];
    rd_byte_d = 8'h00;
    if (cmd_q == CMD_SNS)     rd_byte_d = sense_q;
    else if (cmd_q == CMD_RD) rd_byte_d = mem_q[rd_addr_d];
  end

  // Buffer write: one byte per accepted WRITE service handshake.
  logic mem_we_d;
  assign mem_we_d = !reset && b_operational_out && (state_q == S_DATA) &&
                    b_service_out && (cmd_q == CMD_WR);

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[count_q[AW-1:0]] <= b_bus_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bus_in_q     <= 8'h00;
      op_in_q      <= 1'b0;
      addr_in_q    <= 1'b0;
      status_in_q  <= 1'b0;
      service_in_q <= 1'b0;
      sel_in_q     <= 1'b0;
      a_sel_q      <= 1'b0;
      cmd_q        <= 8'h00;
      dev_q        <= 4'h0;
      count_q      <= 9'd0;
      selected_q   <= 1'b0;
      sense_q      <= 8'h00;
      status_q     <= 8'h00;
    end else if (!b_operational_out) begin
      // Channel clear: drop every inbound tag, keep sense and buffer.
      state_q      <= S_IDLE;
      bus_in_q     <= 8'h00;
      op_in_q      <= 1'b0;
      addr_in_q    <= 1'b0;
      status_in_q  <= 1'b0;
      service_in_q <= 1'b0;
      sel_in_q     <= 1'b0;
      a_sel_q      <= 1'b0;
      selected_q   <= 1'b0;
    end else begin
      sel_in_q <= a_select_in;
      a_sel_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (addr_hit_d) begin
            dev_q      <= dev_off_d[3:0];
            selected_q <= 1'b1;
            op_in_q    <= 1'b1;
            if (mock_busy && ENABLE_SHORT_BUSY) begin
              status_in_q <= 1'b1;
              bus_in_q    <= ST_SBUSY;
              state_q     <= S_SBUSY;
            end else begin
              state_q <= S_ADDR_WAIT;
            end
          end else begin
            a_sel_q <= b_select_out;
          end
        end
        S_SBUSY: begin
          if (b_service_out) begin
            status_in_q <= 1'b0;
            bus_in_q    <= 8'h00;
            state_q     <= S_SBUSY_WAIT;
          end
        end
        S_SBUSY_WAIT: begin
          if (!b_service_out) begin
            op_in_q    <= 1'b0;
            selected_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        S_ADDR_WAIT: begin
          if (!b_address_out) begin
            addr_in_q <= 1'b1;
            bus_in_q  <= BASE_ADDRESS + {4'h0, dev_q};
            state_q   <= S_ADDR_IN;
          end
        end
        S_ADDR_IN: begin
          if (b_command_out) begin
            cmd_q     <= b_bus_out;
            addr_in_q <= 1'b0;
            bus_in_q  <= 8'h00;
            state_q   <= S_CMD_WAIT;
          end
        end
        S_CMD_WAIT: begin
          if (!b_command_out) begin
            status_q    <= init_st_d;
            bus_in_q    <= init_st_d;
            status_in_q <= 1'b1;
            if (reject_d) sense_q[7] <= 1'b1;
            state_q     <= S_INIT_STATUS;
          end
        end
        S_INIT_STATUS: begin
          if (b_service_out) begin
            status_in_q <= 1'b0;
            bus_in_q    <= 8'h00;
            state_q     <= S_INIT_WAIT;
          end
        end
        S_INIT_WAIT: begin
          if (!b_service_out) begin
            // Any non-zero status, or TEST I/O, closes the operation here.
            if (status_q != ST_OK || cmd_q == CMD_TIO) begin
              op_in_q    <= 1'b0;
              selected_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              count_q <= 9'd0;
              if (xfer_lim_d == 9'd0) begin
                status_in_q <= 1'b1;
                bus_in_q    <= ST_END;
                state_q     <= S_END_STATUS;
              end else begin
                service_in_q <= 1'b1;
                bus_in_q     <= rd_byte_d;
                state_q      <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (b_service_out) begin
            if (cmd_q == CMD_SNS) sense_q <= 8'h00;
            count_q      <= count_q + 9'd1;
            service_in_q <= 1'b0;
            bus_in_q     <= 8'h00;
            state_q      <= S_DATA_WAIT;
          end else if (b_command_out) begin
            // STOP: channel answers service-in with command-out.
            service_in_q <= 1'b0;
            bus_in_q     <= 8'h00;
            state_q      <= S_STOP_WAIT;
          end
        end
        S_DATA_WAIT: begin
          if (!b_service_out) begin
            if (count_q == xfer_lim_d) begin
              status_in_q <= 1'b1;
              bus_in_q    <= ST_END;
              state_q     <= S_END_STATUS;
            end else if (count_q == 9'(BUFFER_DEPTH)) begin
              sense_q[3]  <= 1'b1;
              status_in_q <= 1'b1;
              bus_in_q    <= ST_OVERRUN;
              state_q     <= S_END_STATUS;
            end else begin
              service_in_q <= 1'b1;
              bus_in_q     <= rd_byte_d;
              state_q      <= S_DATA;
            end
          end
        end
        S_STOP_WAIT: begin
          if (!b_command_out) begin
            status_in_q <= 1'b1;
            bus_in_q    <= ST_END;
            state_q     <= S_END_STATUS;
          end
        end
        S_END_STATUS: begin
          if (b_service_out) begin
            status_in_q <= 1'b0;
            bus_in_q    <= 8'h00;
            op_in_q     <= 1'b0;
            selected_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          bus_in_q     <= 8'h00;
          op_in_q      <= 1'b0;
          addr_in_q    <= 1'b0;
          status_in_q  <= 1'b0;
          service_in_q <= 1'b0;
          selected_q   <= 1'b0;
        end
      endcase
    end
  end

  assign b_bus_in         = bus_in_q;
  assign b_request_in     = 1'b0;
  assign b_select_in      = sel_in_q;
  assign b_operational_in = op_in_q;
  assign b_address_in     = addr_in_q;
  assign b_status_in      = status_in_q;
  assign b_service_in     = service_in_q;
  assign a_select_out     = a_sel_q;
  assign command          = cmd_q;
  assign device           = dev_q;
  assign count            = count_q;
  assign selected         = selected_q;

  // Hold-out and suppress-out are not used by this unit.
  logic unused_bits;
  assign unused_bits = ^{b_hold_out, b_suppress_out, dev_off_d[7:4]};

endmodule

// File: tb/tb_mock_cu_multi.sv
module tb_mock_cu_multi;
  localparam logic [7:0] BASE  = 8'h10;
  localparam int         NDEV  = 4;
  localparam int         DEPTH = 64;
  localparam int OPI = 0, ADI = 1, STI = 2, SVI = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] b_bus_in, b_bus_out;
  logic       b_operational_out, b_request_in, b_hold_out, b_select_out;
  logic       b_select_in, b_address_out, b_operational_in, b_address_in;
  logic       b_command_out, b_status_in, b_service_in, b_service_out;
  logic       b_suppress_out, a_select_out, a_select_in, mock_busy;
  logic [7:0] mock_limit, command;
  logic [3:0] device;
  logic [8:0] count;
  logic       selected;

  int n_checks = 0;
  int n_fail   = 0;

  // Channel-side buffers and reference model state
  logic [7:0] wbuf [256];
  logic [7:0] rbuf [256];
  logic [7:0] mem_m [DEPTH];
  logic [7:0] sense_m;

  mock_cu_multi #(.BASE_ADDRESS(BASE), .NUM_DEVICES(NDEV),
                  .BUFFER_DEPTH(DEPTH), .ENABLE_SHORT_BUSY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .b_bus_in(b_bus_in), .b_bus_out(b_bus_out),
    .b_operational_out(b_operational_out), .b_request_in(b_request_in),
    .b_hold_out(b_hold_out), .b_select_out(b_select_out),
    .b_select_in(b_select_in), .b_address_out(b_address_out),
    .b_operational_in(b_operational_in), .b_address_in(b_address_in),
    .b_command_out(b_command_out), .b_status_in(b_status_in),
    .b_service_in(b_service_in), .b_service_out(b_service_out),
    .b_suppress_out(b_suppress_out), .a_select_out(a_select_out),
    .a_select_in(a_select_in), .mock_busy(mock_busy),
    .mock_limit(mock_limit), .command(command), .device(device),
    .count(count), .selected(selected)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic sig(input int s);
    case (s)
      OPI:     return b_operational_in;
      ADI:     return b_address_in;
      STI:     return b_status_in;
      default: return b_service_in;
    endcase
  endfunction

  // Bounded wait for an inbound tag; an expired bound counts as a failure.
  task automatic wait_sig(input int s, input logic v, input string what);
    int t = 0;
    do begin @(negedge clk); t++; end while (sig(s) !== v && t < 50);
    if (sig(s) !== v) begin
      n_checks++; n_fail++;
      $display("FAIL timeout %s: tag %0d is %b, required %b", what, s, sig(s), v);
    end
  endtask

  // Reference: bytes moved and ending status from the operation rules.
  function automatic void model(input logic [7:0] cmd, input logic [7:0] lim,
                                input int stop, output int n, output logic [7:0] est);
    int  eff;
    bit  ovr;
    eff = (cmd == 8'h04) ? 1 : int'(lim);
    ovr = 1'b0;
    n   = eff;
    if (cmd != 8'h04 && eff > DEPTH) begin n = DEPTH; ovr = 1'b1; end
    if (stop >= 0 && stop < n) begin n = stop; ovr = 1'b0; end
    est = ovr ? 8'h32 : 8'h30;
  endfunction

  task automatic commit(input logic [7:0] cmd, input int n, input logic [7:0] est);
    if (cmd == 8'h01) for (int k = 0; k < n; k++) mem_m[k] = wbuf[k];
    if (cmd == 8'h04 && n == 1) sense_m = 8'h00;
    if (est == 8'h32) sense_m[3] = 1'b1;
  endtask

  // Channel: select, address, command, initial status.
  task automatic do_cmd(input logic [7:0] addr, input logic [7:0] cmd,
                        output logic [7:0] echo, output logic [7:0] ist);
    @(negedge clk);
    b_bus_out = addr; b_select_out = 1'b1; b_address_out = 1'b1;
    wait_sig(OPI, 1'b1, "operational_in");
    b_address_out = 1'b0; b_bus_out = 8'h00;
    wait_sig(ADI, 1'b1, "address_in");
    echo = b_bus_in;
    b_bus_out = cmd; b_command_out = 1'b1;
    wait_sig(ADI, 1'b0, "address_in drop");
    b_command_out = 1'b0; b_bus_out = 8'h00;
    wait_sig(STI, 1'b1, "initial status");
    ist = b_bus_in;
    b_service_out = 1'b1;
    wait_sig(STI, 1'b0, "initial status drop");
    b_service_out = 1'b0;
  endtask

  // Channel: data phase (optionally STOP before byte 'stop') and ending status.
  task automatic do_data(input int stop, output int n, output logic [7:0] est);
    bit done = 1'b0;
    n = 0; est = 8'hxx;
    for (int it = 0; it < 300 && !done; it++) begin
      int t = 0;
      do begin @(negedge clk); t++; end
      while (b_service_in !== 1'b1 && b_status_in !== 1'b1 && t < 50);
      if (b_status_in === 1'b1) begin
        est = b_bus_in;
        b_service_out = 1'b1;
        wait_sig(STI, 1'b0, "ending status drop");
        b_service_out = 1'b0;
        done = 1'b1;
      end else if (b_service_in === 1'b1) begin
        if (n == stop) begin
          b_command_out = 1'b1;
          wait_sig(SVI, 1'b0, "service_in drop on stop");
          b_command_out = 1'b0;
        end else begin
          rbuf[n] = b_bus_in;
          b_bus_out = wbuf[n]; b_service_out = 1'b1;
          wait_sig(SVI, 1'b0, "service_in drop");
          b_service_out = 1'b0; b_bus_out = 8'h00;
          n++;
        end
      end else begin
        n_checks++; n_fail++;
        $display("FAIL timeout data phase: no service_in/status_in after %0d bytes", n);
        done = 1'b1;
      end
    end
  endtask

  task automatic xfer(input logic [7:0] addr, input logic [7:0] cmd, input logic [7:0] lim,
                      input int stop, output logic [7:0] echo, output logic [7:0] ist,
                      output logic [7:0] est, output int n);
    mock_limit = lim;
    do_cmd(addr, cmd, echo, ist);
    n = 0; est = 8'hxx;
    if (ist === 8'h00 && (cmd == 8'h01 || cmd == 8'h02 || cmd == 8'h04))
      do_data(stop, n, est);
    b_select_out = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; b_operational_out = 1'b1; b_select_out = 1'b1; a_select_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({b_bus_in, b_request_in, b_select_in, b_operational_in, b_address_in, b_status_in,
         b_service_in, a_select_out, command, device, count, selected} !== '0) begin
      n_fail++;
      $display("FAIL reset: bus_in=%h opi=%b asel=%b cmd=%h dev=%h cnt=%0d sel=%b, required all 0",
               b_bus_in, b_operational_in, a_select_out, command, device, count, selected);
    end
    b_select_out = 1'b0; a_select_in = 1'b0; reset = 1'b0;
    sense_m = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_nop();
    logic [7:0] e, i, s; int n;
    xfer(BASE + 8'd2, 8'h03, 8'd0, -1, e, i, s, n);
    n_checks++;
    if (e !== 8'h12 || i !== 8'h30 || device !== 4'd2 || command !== 8'h03) begin
      n_fail++;
      $display("FAIL nop: echo=%h init=%h dev=%0d cmd=%h, required 12 30 2 03", e, i, device, command);
    end
    n_checks++;
    if (selected !== 1'b0 || b_operational_in !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_idle: selected=%b opi=%b, required 0 0", selected, b_operational_in);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] addrs [2];
    addrs[0] = 8'h0F; addrs[1] = BASE + 8'(NDEV);
    foreach (addrs[j]) begin
      @(negedge clk);
      b_bus_out = addrs[j]; b_select_out = 1'b1; b_address_out = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (b_operational_in !== 1'b0 || selected !== 1'b0 || a_select_out !== 1'b1) begin
        n_fail++;
        $display("FAIL out_of_range %h: opi=%b sel=%b asel=%b, required 0 0 1",
                 addrs[j], b_operational_in, selected, a_select_out);
      end
      b_select_out = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_select_out !== 1'b0) begin
        n_fail++;
        $display("FAIL asel_follow %h: asel=%b, required 0", addrs[j], a_select_out);
      end
      b_address_out = 1'b0; b_bus_out = 8'h00;
    end
    a_select_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b_select_in !== 1'b1) begin
      n_fail++; $display("FAIL select_in copy: got %b, required 1", b_select_in);
    end
    a_select_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_testio();
    logic [7:0] e, i, s; int n;
    xfer(BASE, 8'h00, 8'd5, -1, e, i, s, n);
    n_checks++;
    if (i !== 8'h00 || n != 0 || selected !== 1'b0 || device !== 4'd0) begin
      n_fail++;
      $display("FAIL testio: init=%h bytes=%0d sel=%b dev=%0d, required 00 0 0 0", i, n, selected, device);
    end
  endtask

  task automatic test_reject_sense();
    logic [7:0] e, i, s; int n;
    xfer(BASE + 8'd1, 8'hFF, 8'd3, -1, e, i, s, n);
    n_checks++;
    if (i !== 8'h70 || command !== 8'hFF || selected !== 1'b0) begin
      n_fail++;
      $display("FAIL reject: init=%h cmd=%h sel=%b, required 70 FF 0", i, command, selected);
    end
    sense_m[7] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      logic [7:0] exp_b = sense_m;
      xfer(BASE + 8'd1, 8'h04, 8'd0, -1, e, i, s, n);
      n_checks++;
      if (i !== 8'h00 || n != 1 || rbuf[0] !== exp_b || s !== 8'h30 || count !== 9'd1) begin
        n_fail++;
        $display("FAIL sense%0d: init=%h bytes=%0d byte=%h end=%h cnt=%0d, required 00 1 %h 30 1",
                 r, i, n, rbuf[0], s, count, exp_b);
      end
      commit(8'h04, 1, 8'h30);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] e, i, s, xs; int n, xn;
    for (int k = 0; k < 5; k++) wbuf[k] = 8'hA1 + 8'(k);
    model(8'h01, 8'd5, -1, xn, xs);
    xfer(BASE + 8'd3, 8'h01, 8'd5, -1, e, i, s, n);
    n_checks++;
    if (i !== 8'h00 || s !== xs || n != xn || count !== 9'(xn)) begin
      n_fail++;
      $display("FAIL write5: init=%h end=%h bytes=%0d cnt=%0d, required 00 %h %0d", i, s, n, count, xs, xn);
    end
    commit(8'h01, xn, xs);
    model(8'h02, 8'd5, -1, xn, xs);
    xfer(BASE + 8'd3, 8'h02, 8'd5, -1, e, i, s, n);
    n_checks++;
    if (i !== 8'h00 || s !== xs || n != xn || count !== 9'(xn)) begin
      n_fail++;
      $display("FAIL read5: init=%h end=%h bytes=%0d cnt=%0d, required 00 %h %0d", i, s, n, count, xs, xn);
    end
    for (int k = 0; k < xn; k++) begin
      n_checks++;
      if (rbuf[k] !== mem_m[k]) begin
        n_fail++; $display("FAIL read5 byte %0d: got %h, required %h", k, rbuf[k], mem_m[k]);
      end
    end
  endtask

  task automatic test_stop();
    logic [7:0] e, i, s, xs; int n, xn;
    model(8'h02, 8'd10, 3, xn, xs);
    xfer(BASE, 8'h02, 8'd10, 3, e, i, s, n);
    n_checks++;
    if (s !== xs || n != xn || count !== 9'(xn)) begin
      n_fail++;
      $display("FAIL stop: end=%h bytes=%0d cnt=%0d, required %h %0d", s, n, count, xs, xn);
    end
    for (int k = 0; k < xn; k++) begin
      n_checks++;
      if (rbuf[k] !== mem_m[k]) begin
        n_fail++; $display("FAIL stop byte %0d: got %h, required %h", k, rbuf[k], mem_m[k]);
      end
    end
  endtask

  task automatic test_zero_limit();
    logic [7:0] e, i, s; int n;
    xfer(BASE + 8'd1, 8'h02, 8'd0, -1, e, i, s, n);
    n_checks++;
    if (i !== 8'h00 || n != 0 || s !== 8'h30 || count !== 9'd0) begin
      n_fail++;
      $display("FAIL zero_limit: init=%h bytes=%0d end=%h cnt=%0d, required 00 0 30 0", i, n, s, count);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] e, i, s, xs, exp_b; int n, xn;
    for (int k = 0; k < 70; k++) wbuf[k] = 8'($urandom);
    model(8'h01, 8'd70, -1, xn, xs);
    xfer(BASE + 8'd2, 8'h01, 8'd70, -1, e, i, s, n);
    n_checks++;
    if (s !== xs || n != xn || count !== 9'(xn)) begin
      n_fail++;
      $display("FAIL overrun: end=%h bytes=%0d cnt=%0d, required %h %0d", s, n, count, xs, xn);
    end
    commit(8'h01, xn, xs);
    exp_b = sense_m;
    xfer(BASE + 8'd2, 8'h04, 8'd9, -1, e, i, s, n);
    n_checks++;
    if (n != 1 || rbuf[0] !== exp_b || s !== 8'h30) begin
      n_fail++;
      $display("FAIL overrun sense: bytes=%0d byte=%h end=%h, required 1 %h 30", n, rbuf[0], s, exp_b);
    end
    commit(8'h04, 1, 8'h30);
    model(8'h02, 8'(DEPTH), -1, xn, xs);
    xfer(BASE + 8'd2, 8'h02, 8'(DEPTH), -1, e, i, s, n);
    n_checks++;
    if (s !== xs || n != xn) begin
      n_fail++; $display("FAIL full read: end=%h bytes=%0d, required %h %0d", s, n, xs, xn);
    end
    for (int k = 0; k < xn; k++) begin
      n_checks++;
      if (rbuf[k] !== mem_m[k]) begin
        n_fail++; $display("FAIL full read byte %0d: got %h, required %h", k, rbuf[k], mem_m[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] e, i, s, xs, lim, lim2, dv; int n, xn, stop;
      dv  = 8'($urandom_range(0, NDEV - 1));
      lim = 8'($urandom_range(1, 40));
      for (int k = 0; k < int'(lim); k++) wbuf[k] = 8'($urandom);
      model(8'h01, lim, -1, xn, xs);
      xfer(BASE + dv, 8'h01, lim, -1, e, i, s, n);
      n_checks++;
      if (e !== BASE + dv || device !== dv[3:0] || s !== xs || n != xn || count !== 9'(xn)) begin
        n_fail++;
        $display("FAIL rnd write %0d: echo=%h dev=%0d end=%h bytes=%0d cnt=%0d, required %h %0d %h %0d",
                 it, e, device, s, n, count, BASE + dv, dv, xs, xn);
      end
      commit(8'h01, xn, xs);
      lim2 = 8'($urandom_range(1, int'(lim)));
      stop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(lim2) - 1)) : -1;
      model(8'h02, lim2, stop, xn, xs);
      xfer(BASE + dv, 8'h02, lim2, stop, e, i, s, n);
      n_checks++;
      if (s !== xs || n != xn || count !== 9'(xn)) begin
        n_fail++;
        $display("FAIL rnd read %0d: end=%h bytes=%0d cnt=%0d, required %h %0d", it, s, n, count, xs, xn);
      end
      for (int k = 0; k < xn; k++) begin
        n_checks++;
        if (rbuf[k] !== mem_m[k]) begin
          n_fail++; $display("FAIL rnd read %0d byte %0d: got %h, required %h", it, k, rbuf[k], mem_m[k]);
        end
      end
    end
  endtask

  task automatic test_short_busy();
    mock_busy = 1'b1;
    @(negedge clk);
    b_bus_out = BASE + 8'd1; b_select_out = 1'b1; b_address_out = 1'b1;
    wait_sig(STI, 1'b1, "short busy status");
    n_checks++;
    if (b_bus_in !== 8'h48 || b_address_in !== 1'b0 || b_operational_in !== 1'b1 || selected !== 1'b1) begin
      n_fail++;
      $display("FAIL short_busy: bus=%h adi=%b opi=%b sel=%b, required 48 0 1 1",
               b_bus_in, b_address_in, b_operational_in, selected);
    end
    b_service_out = 1'b1; b_address_out = 1'b0; b_bus_out = 8'h00;
    wait_sig(STI, 1'b0, "short busy drop");
    b_service_out = 1'b0; b_select_out = 1'b0;
    @(negedge clk);
    n_checks++;
    if (selected !== 1'b0 || b_operational_in !== 1'b0) begin
      n_fail++;
      $display("FAIL short_busy end: sel=%b opi=%b, required 0 0", selected, b_operational_in);
    end
    mock_busy = 1'b0;
  endtask

  task automatic test_op_drop();
    logic [7:0] e, i, s; int n;
    mock_limit = 8'd10;
    do_cmd(BASE + 8'd3, 8'h02, e, i);
    wait_sig(SVI, 1'b1, "read service_in");
    b_operational_out = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b_operational_in, b_address_in, b_status_in, b_service_in, selected} !== 5'b0 ||
        b_bus_in !== 8'h00) begin
      n_fail++;
      $display("FAIL op_drop: opi=%b adi=%b sti=%b svi=%b sel=%b bus=%h, required all 0",
               b_operational_in, b_address_in, b_status_in, b_service_in, selected, b_bus_in);
    end
    b_operational_out = 1'b1; b_select_out = 1'b0;
    @(negedge clk);
    xfer(BASE, 8'h03, 8'd0, -1, e, i, s, n);
    n_checks++;
    if (e !== BASE || i !== 8'h30) begin
      n_fail++; $display("FAIL after op_drop: echo=%h init=%h, required %h 30", e, i, BASE);
    end
  endtask

  initial begin
    b_bus_out = 8'h00; b_operational_out = 1'b1; b_hold_out = 1'b0; b_select_out = 1'b0;
    b_address_out = 1'b0; b_command_out = 1'b0; b_service_out = 1'b0; b_suppress_out = 1'b0;
    a_select_in = 1'b0; mock_busy = 1'b0; mock_limit = 8'h00; reset = 1'b1;
    test_reset();
    test_nop();
    test_out_of_range();
    test_testio();
    test_reject_sense();
    test_write_read();
    test_stop();
    test_zero_limit();
    test_overrun();
    test_random();
    test_short_busy();
    test_op_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
